// File: rtl/hazard_unit.sv
// hazard_unit -- load-use hazard detection for the ID stage.
//
// Compares the two ID-stage source registers against the destination of a
// load sitting in EX. On a match the unit freezes PC and IF/ID for one cycle
// and turns the ID/EX contents into a bubble. The bubble carries memRead = 0,
// so the hazard clears by itself on the following cycle.
//
// Optional feature, macro HAZARD_STALL_CNT_EN:
//   defined   -> stallCount port plus a CNT_W-bit saturating stall counter
//                clocked by clk, cleared asynchronously by rst.
//   undefined -> purely combinational; clk and rst are present but unused.
//
// Ports:
//   clk        in   clock (stall counter only)
//   rst        in   asynchronous active-high reset (stall counter only)
//   RA1_ID     in   ID source register 1
//   RA2_ID     in   ID source register 2
//   RA1_EX     in   EX destination register (load target)
//   memRead_EX in   EX instruction is a load
//   hazard     out  load-use hazard this cycle (combinational)
//   pcWrite    out  PC write enable        (~hazard)
//   ifidWrite  out  IF/ID write enable     (~hazard)
//   idexFlush  out  ID/EX bubble insertion ( hazard)
//   stallCount out  saturating stall-cycle count (macro only)
module hazard_unit #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] RA1_ID,
  input  logic [ADDR_W-1:0] RA2_ID,
  input  logic [ADDR_W-1:0] RA1_EX,
  input  logic              memRead_EX,
  output logic              hazard,
  output logic              pcWrite,
  output logic              ifidWrite,
  output logic              idexFlush
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stallCount
`endif
);

  // Register 0 is compared like any other register; a double match still
  // yields a single hazard. Reset does not gate these outputs.
  assign hazard    = memRead_EX && ((RA1_ID == RA1_EX) || (RA2_ID == RA1_EX));
  assign pcWrite   = ~hazard;
  assign ifidWrite = ~hazard;
  assign idexFlush = hazard;

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stallCount = stall_cnt_q;
`else
  // clk and rst have no load in the combinational-only build.
  logic unused_clk_rst;
  assign unused_clk_rst = ^{clk, rst};
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  localparam int ADDR_W = 4;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] RA1_ID;
  logic [ADDR_W-1:0] RA2_ID;
  logic [ADDR_W-1:0] RA1_EX;
  logic              memRead_EX;
  logic              hazard;
  logic              pcWrite;
  logic              ifidWrite;
  logic              idexFlush;
`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0]  stallCount;
`endif

  hazard_unit #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RA1_ID    (RA1_ID),
    .RA2_ID    (RA2_ID),
    .RA1_EX    (RA1_EX),
    .memRead_EX(memRead_EX),
    .hazard    (hazard),
    .pcWrite   (pcWrite),
    .ifidWrite (ifidWrite),
    .idexFlush (idexFlush)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stallCount(stallCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic       h;
    logic       chk_cnt;
    logic [1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check1(input int id, input string nm, input logic act, input logic req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL vec%0d %s: got %b expected %b", id, nm, act, req);
  endtask

  // Monitor: outputs are combinational, so they are presented every cycle;
  // sample on the falling edge, half a cycle after the stimulus changed.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check1(e.id, "hazard",    hazard,    e.h);
      check1(e.id, "pcWrite",   pcWrite,   ~e.h);
      check1(e.id, "ifidWrite", ifidWrite, ~e.h);
      check1(e.id, "idexFlush", idexFlush, e.h);
`ifdef HAZARD_STALL_CNT_EN
      if (e.chk_cnt) begin
        n_checks++;
        if (stallCount === e.cnt) n_pass++;
        else $display("FAIL vec%0d stallCount: got %0d expected %0d", e.id, stallCount, e.cnt);
      end
`endif
    end
  end

  int vid = 0;

  // Drive one vector just after a rising edge and queue its expectation.
  task automatic apply(input logic r, input logic [3:0] a1, input logic [3:0] a2,
                       input logic [3:0] ex, input logic mr, input logic exp_h,
                       input logic chk, input logic [1:0] exp_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst        = r;
    RA1_ID     = a1;
    RA2_ID     = a2;
    RA1_EX     = ex;
    memRead_EX = mr;
    e.id = vid; e.h = exp_h; e.chk_cnt = chk; e.cnt = exp_cnt;
    q.push_back(e);
    vid++;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; RA1_ID = '0; RA2_ID = '0; RA1_EX = '0; memRead_EX = 1'b0;

    // Under reset: counter cleared, combinational outputs still live.
    apply(1, 4'd3, 4'd4, 4'd3, 1, 1'b1, 1'b1, 2'd0);
    apply(1, 4'd3, 4'd4, 4'd5, 1, 1'b0, 1'b1, 2'd0);

    // Directed vectors (counter not checked here).
    apply(0, 4'd0,  4'd1,  4'd1,  0, 1'b0, 1'b0, 2'd0); // no load
    apply(0, 4'd1,  4'd2,  4'd1,  0, 1'b0, 1'b0, 2'd0); // no load, src1 match
    apply(0, 4'd1,  4'd2,  4'd2,  0, 1'b0, 1'b0, 2'd0); // no load, src2 match
    apply(0, 4'd0,  4'd1,  4'd2,  1, 1'b0, 1'b0, 2'd0); // load, no dep
    apply(0, 4'd1,  4'd2,  4'd1,  1, 1'b1, 1'b0, 2'd0); // load, src1 dep
    apply(0, 4'd1,  4'd2,  4'd2,  1, 1'b1, 1'b0, 2'd0); // load, src2 dep
    apply(0, 4'd15, 4'd15, 4'd15, 1, 1'b1, 1'b0, 2'd0); // all 15
    apply(0, 4'd0,  4'd0,  4'd0,  1, 1'b1, 1'b0, 2'd0); // all 0
    apply(0, 4'd7,  4'd8,  4'd9,  1, 1'b0, 1'b0, 2'd0); // load, no dep
    apply(0, 4'd0,  4'd0,  4'd0,  0, 1'b0, 1'b0, 2'd0); // reg0 ALU dep

`ifdef HAZARD_STALL_CNT_EN
    // Fresh reset, then hold a hazard: count each edge, saturate at 3.
    apply(1, 4'd0, 4'd1, 4'd2, 1, 1'b0, 1'b1, 2'd0);
    apply(0, 4'd4, 4'd5, 4'd4, 1, 1'b1, 1'b1, 2'd0);
    apply(0, 4'd4, 4'd5, 4'd4, 1, 1'b1, 1'b1, 2'd1);
    apply(0, 4'd4, 4'd5, 4'd4, 1, 1'b1, 1'b1, 2'd2);
    apply(0, 4'd4, 4'd5, 4'd4, 1, 1'b1, 1'b1, 2'd3);
    apply(0, 4'd4, 4'd5, 4'd4, 1, 1'b1, 1'b1, 2'd3);
    apply(0, 4'd4, 4'd5, 4'd4, 1, 1'b1, 1'b1, 2'd3);
    // rst mid-stall, between edges: clears at once, hazard unaffected.
    apply(1, 4'd4, 4'd5, 4'd4, 1, 1'b1, 1'b1, 2'd0);
    // Released with hazard high: the edge seen was still in reset.
    apply(0, 4'd4, 4'd5, 4'd4, 1, 1'b1, 1'b1, 2'd0);
    apply(0, 4'd4, 4'd5, 4'd4, 1, 1'b1, 1'b1, 2'd1);
    // Hazard drops: one more count from the last hazard edge, then hold.
    apply(0, 4'd4, 4'd5, 4'd4, 0, 1'b0, 1'b1, 2'd2);
    apply(0, 4'd4, 4'd5, 4'd4, 0, 1'b0, 1'b1, 2'd2);
    apply(0, 4'd1, 4'd2, 4'd3, 1, 1'b0, 1'b1, 2'd2);
    apply(0, 4'd1, 4'd2, 4'd3, 1, 1'b0, 1'b1, 2'd2);
`endif

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
